// File: rtl/timer_pkg.sv
// Shared constants for the multi-mode timer: FSM encoding, mode values and
// default widths.
package timer_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic MODE_PERIODIC = 1'b0;
  localparam logic MODE_ONESHOT  = 1'b1;

  localparam int DEFAULT_WIDTH          = 24;
  localparam int DEFAULT_PRESCALE_WIDTH = 8;

endpackage

// File: rtl/tick_prescaler.sv
// Clock-enable divider: issues a one-cycle tick every prescale+1 run cycles.
// The tick is combinational on the held prescaler state so the counter acts on the same edge.
module tick_prescaler
  import timer_pkg::*;
#(
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic                      reload,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  output logic                      tick
);

  localparam logic [PRESCALE_WIDTH-1:0] PRE_ONE = PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] pre;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre <= '0;
    end else if (reload) begin
      pre <= prescale;
    end else if (run) begin
      if (pre == '0) begin
        pre <= prescale;
      end else begin
        pre <= pre - PRE_ONE;
      end
    end
  end

  // A reload cycle never ticks: start re-arms the full prescale interval.
  assign tick = run & ~reload & (pre == '0);

endmodule

// File: rtl/multi_mode_timer.sv
// Programmable down-counting timer with prescaler, periodic/one-shot modes,
// terminal pulse, toggle output and compare-driven PWM. All outputs registered.
module multi_mode_timer
  import timer_pkg::*;
#(
  parameter int WIDTH          = DEFAULT_WIDTH,
  parameter int PRESCALE_WIDTH = DEFAULT_PRESCALE_WIDTH
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      start,
  input  logic                      stop,
  input  logic                      oneshot,
  input  logic [WIDTH-1:0]          load_value,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic [WIDTH-1:0]          compare_value,
  output logic [WIDTH-1:0]          count,
  output logic                      zero,
  output logic                      tp,
  output logic                      busy,
  output logic                      pwm,
  output logic [0:0]                dbg_state
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [WIDTH-1:0] count_next;
  logic             zero_next;
  logic             tp_next;
  logic             busy_next;
  logic             pwm_next;
  logic             tick;
  logic             pre_run;

  // Stop is gated out so the prescaler is left untouched on the halting cycle.
  assign pre_run = (state == ST_RUN) & enable & ~stop;

  tick_prescaler #(
    .PRESCALE_WIDTH(PRESCALE_WIDTH)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .run      (pre_run),
    .reload   (start),
    .prescale (prescale),
    .tick     (tick)
  );

  always_comb begin
    state_next = state;
    count_next = count;
    zero_next  = 1'b0;
    tp_next    = tp;
    if (start) begin
      state_next = ST_RUN;
      count_next = load_value;
    end else if (stop) begin
      state_next = ST_IDLE;
    end else if (tick) begin
      if (count != '0) begin
        count_next = count - CNT_ONE;
      end else begin
        zero_next = 1'b1;
        tp_next   = ~tp;
        if (oneshot == MODE_ONESHOT) begin
          state_next = ST_IDLE;
        end else begin
          count_next = load_value;
        end
      end
    end
    busy_next = (state_next == ST_RUN);
    pwm_next  = busy_next & (count_next < compare_value);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= ST_IDLE;
      count <= '0;
      zero  <= 1'b0;
      tp    <= 1'b0;
      busy  <= 1'b0;
      pwm   <= 1'b0;
    end else begin
      state <= state_next;
      count <= count_next;
      zero  <= zero_next;
      tp    <= tp_next;
      busy  <= busy_next;
      pwm   <= pwm_next;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_multi_mode_timer.sv
// Directed bench for multi_mode_timer (WIDTH=8, PRESCALE_WIDTH=4) with hand-computed expectations.
module tb_multi_mode_timer;

  localparam int W  = 8;
  localparam int PW = 4;

  logic          clk;
  logic          reset;
  logic          enable;
  logic          start;
  logic          stop;
  logic          oneshot;
  logic [W-1:0]  load_value;
  logic [PW-1:0] prescale;
  logic [W-1:0]  compare_value;
  logic [W-1:0]  count;
  logic          zero;
  logic          tp;
  logic          busy;
  logic          pwm;
  logic [0:0]    dbg_state;

  int total;
  int bad;

  multi_mode_timer #(
    .WIDTH          (W),
    .PRESCALE_WIDTH (PW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .start         (start),
    .stop          (stop),
    .oneshot       (oneshot),
    .load_value    (load_value),
    .prescale      (prescale),
    .compare_value (compare_value),
    .count         (count),
    .zero          (zero),
    .tp            (tp),
    .busy          (busy),
    .pwm           (pwm),
    .dbg_state     (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  logic [W-1:0] exp_cnt_a [8];
  logic         exp_zero_a[8];
  logic         exp_tp_a  [8];
  logic [W-1:0] exp_cnt_b [12];
  logic         tp_hold;
  int           n_hi;
  int           n_zero;
  int           first_z;
  int           second_z;

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1; enable = 1'b0; start = 1'b0; stop = 1'b0; oneshot = 1'b0;
    load_value = '0; prescale = '0; compare_value = '0;

    // reset state
    do_reset();
    check("rst_count", count, 0);
    check("rst_zero", zero, 0);
    check("rst_tp", tp, 0);
    check("rst_busy", busy, 0);
    check("rst_pwm", pwm, 0);
    check("rst_state", dbg_state, 0);

    // basic periodic: 3,2,1,0,3...
    exp_cnt_a  = '{8'd2, 8'd1, 8'd0, 8'd3, 8'd2, 8'd1, 8'd0, 8'd3};
    exp_zero_a = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    exp_tp_a   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    load_value = 8'd3; prescale = 4'd0; oneshot = 1'b0; enable = 1'b1;
    pulse_start();
    check("per_start_count", count, 3);
    check("per_start_busy", busy, 1);
    for (int i = 0; i < 8; i++) begin
      step();
      check($sformatf("per_count[%0d]", i), count, exp_cnt_a[i]);
      check($sformatf("per_zero[%0d]", i), zero, exp_zero_a[i]);
      check($sformatf("per_tp[%0d]", i), tp, exp_tp_a[i]);
    end

    // PWM with compare 2: high for count 1,0 -> 4 of 8 cycles
    compare_value = 8'd2;
    pulse_start();
    check("pwm_start", pwm, 0);
    n_hi = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (pwm) n_hi++;
      if (count == 8'd1) check("pwm_at_1", pwm, 1);
      if (count == 8'd3) check("pwm_at_3", pwm, 0);
    end
    check("pwm_hi_cycles", n_hi, 4);
    compare_value = 8'd0;
    n_hi = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (pwm) n_hi++;
    end
    check("pwm_cmp0_hi", n_hi, 0);

    // prescaled: load 1, prescale 2 -> period 6, each value held 3 cycles
    exp_cnt_b = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
    load_value = 8'd1; prescale = 4'd2;
    pulse_start();
    check("pre_start_count", count, 1);
    n_zero = 0; first_z = -1; second_z = -1;
    for (int i = 0; i < 12; i++) begin
      step();
      check($sformatf("pre_count[%0d]", i), count, exp_cnt_b[i]);
      if (zero) begin
        n_zero++;
        if (first_z < 0) first_z = i + 1;
        else if (second_z < 0) second_z = i + 1;
      end
    end
    check("pre_zero_n", n_zero, 2);
    check("pre_zero_first", first_z, 6);
    check("pre_zero_period", second_z - first_z, 6);

    // one-shot: load 2, prescale 0
    oneshot = 1'b1; load_value = 8'd2; prescale = 4'd0;
    pulse_start();
    step(); check("os_c1", count, 1); check("os_z1", zero, 0);
    step(); check("os_c0", count, 0); check("os_z2", zero, 0);
    step(); check("os_zero", zero, 1); check("os_busy", busy, 0); check("os_count", count, 0);
    check("os_state", dbg_state, 0);
    n_zero = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (zero) n_zero++;
      check($sformatf("os_idle_busy[%0d]", i), busy, 0);
    end
    check("os_extra_zero", n_zero, 0);
    check("os_final_count", count, 0);

    // enable freeze: load 5, prescale 3
    oneshot = 1'b0; load_value = 8'd5; prescale = 4'd3;
    pulse_start();
    for (int i = 0; i < 4; i++) step();
    check("en_tick_count", count, 4);
    step();
    tp_hold = tp;
    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("en_frz_count[%0d]", i), count, 4);
      check($sformatf("en_frz_zero[%0d]", i), zero, 0);
    end
    check("en_frz_tp", tp, tp_hold);
    enable = 1'b1;
    step(); check("en_res1", count, 4);
    step(); check("en_res2", count, 4);
    step(); check("en_res3", count, 3);

    // start + stop together restarts
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    check("ss_count", count, 5);
    check("ss_busy", busy, 1);
    for (int i = 0; i < 4; i++) step();
    check("ss_run_count", count, 4);
    tp_hold = tp;
    stop = 1'b1;
    step();
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_count", count, 4);
    check("stop_zero", zero, 0);
    for (int i = 0; i < 3; i++) step();
    check("stop_hold_count", count, 4);
    check("stop_hold_tp", tp, tp_hold);
    check("stop_state", dbg_state, 0);

    // reset mid-run with count=2, tp=1, start asserted
    do_reset();
    load_value = 8'd3; prescale = 4'd0; compare_value = 8'd4;
    pulse_start();
    for (int i = 0; i < 5; i++) step();
    check("mr_pre_count", count, 2);
    check("mr_pre_tp", tp, 1);
    check("mr_pre_pwm", pwm, 1);
    reset = 1'b0; start = 1'b1;
    step();
    reset = 1'b1; start = 1'b0;
    check("mr_count", count, 0);
    check("mr_zero", zero, 0);
    check("mr_tp", tp, 0);
    check("mr_busy", busy, 0);
    check("mr_pwm", pwm, 0);
    check("mr_state", dbg_state, 0);
    step();
    check("mr_idle_busy", busy, 0);
    check("mr_idle_count", count, 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multi_mode_timer.md
# multi_mode_timer

Parametrised programmable down-counting timer, the next generation of `prog_timer`. It adds configurable counter width and a clock prescaler, and supports periodic and one-shot modes. It has explicit start/stop control and a compare-driven PWM output alongside the existing terminal pulse (`zero`) and toggle (`tp`) outputs. It sits between board-level control logic and anything needing a timebase, such as LED blinkers, debouncers and display refresh.

## Interface

- `WIDTH`, 24, bit width of the main counter, `load_value` and `compare_value`.
- `PRESCALE_WIDTH`, 8, bit width of the prescaler and the `prescale` input.

- `clk` input 1: single clock; all state changes on the rising edge.
- `reset` input 1: synchronous, active-low reset. The clock and reset ports are named `clk` and `reset`. Reset is synchronous and active-low.
- `enable` input 1: when 0, freezes the prescaler and counter; no events occur.
- `start` input 1: load and begin running (level sampled each cycle).
- `stop` input 1: halt and return to IDLE.
- `oneshot` input 1: 0 = periodic (auto-reload), 1 = one-shot.
- `load_value` input WIDTH: reload value; period is `load_value`+1 ticks.
- `prescale` input PRESCALE_WIDTH: one tick occurs every `prescale`+1 enabled cycles.
- `compare_value` input WIDTH: PWM threshold.
- `count` output WIDTH: current counter value.
- `zero` output 1: one-cycle pulse per terminal event.
- `tp` output 1: toggles on every terminal event.
- `busy` output 1: 1 in RUN state.
- `pwm` output 1: `busy` and (`count` < `compare_value`).

## Operation

- States: IDLE and RUN. Reset state is IDLE.
- Reset values: `count`=0, prescaler=0, `zero`=0, `tp`=0, `busy`=0, `pwm`=0.
- Priority, highest first: `reset`, then `start`, then `stop`, then normal counting.
- `start`=1, from any state: `count`←`load_value`, prescaler←`prescale`, state←RUN. This restarts a running timer. `enable` is ignored on this cycle.
- `stop`=1 without `start`: state←IDLE. `count` holds its value, `tp` holds, no `zero` pulse.
- RUN with `enable`=1:
  - Prescaler nonzero: the prescaler decrements.
  - Prescaler = 0: a tick occurs and the prescaler reloads `prescale`. `prescale`=0 gives a tick every enabled cycle.
- On a tick with `count`≠0: `count` decrements.
- On a tick with `count`=0 (terminal event): `zero`←1 for exactly one cycle and `tp` toggles. Then:
  - Periodic mode: `count`←`load_value`. The value is sampled at this edge, so a new value takes effect on the next period.
  - One-shot mode: state←IDLE and `count` stays 0.
- `load_value`=0: a terminal event occurs on every tick.
- `oneshot` is sampled at the terminal edge, not at start.
- IDLE, or RUN with `enable`=0: `count`, prescaler and `tp` hold, and `zero`=0.
- Arithmetic: unsigned. Only the guarded decrements above are allowed, so the counter never wraps below 0.

## Timing

- All outputs are registered, with no combinational input-to-output paths.
- `start` at edge N: `busy`=1 and `count`=`load_value` are visible after edge N.
- Periodic period: (`load_value`+1)×(`prescale`+1) enabled cycles between `zero` pulses. `tp` has a period of twice that.
- The `zero` pulse and the `tp` toggle appear after the same edge as the reload, or as the drop to IDLE in one-shot mode.
- `pwm` is computed from the next-state `count` and `busy`, and is registered with them, so it aligns with `count`.
- Reset asserted mid-RUN: all outputs take their reset values after that edge. A `start` in the same cycle is ignored.

## Structure

- Package `timer_pkg` holds:
  - the state encoding (`ST_IDLE`, `ST_RUN`);
  - the mode constants (`MODE_PERIODIC`=0, `MODE_ONESHOT`=1);
  - the default width constants.
- Sub-module `tick_prescaler`, parametrised by PRESCALE_WIDTH.
  - Inputs: `clk`, `reset`, `run` (= RUN and `enable`), `reload` (= `start`), `prescale`.
  - Output: a one-cycle `tick`.
- The top level holds the FSM, the main counter and the output registers.

## Test plan

- Basic periodic run. Setup: WIDTH=8, PRESCALE_WIDTH=4, `load_value`=3, `prescale`=0, periodic, pulse `start` then hold `enable`=1.
  - `count` sequence: 3,2,1,0,3…
  - `zero` pulses every 4 cycles and `tp` toggles every 4 cycles.
- Prescaled period: `load_value`=1, `prescale`=2 → `zero` period is 6 cycles and each `count` value is held for 3 cycles.
- One-shot run: `oneshot`=1, `load_value`=2, `prescale`=0.
  - Exactly one `zero` pulse, 3 cycles after start.
  - `busy` then drops, `count` stays 0, and there are no further pulses.
- Enable and stop control: `enable` low for 5 cycles mid-run freezes `count`, the prescaler and `tp`.
  - `start` and `stop` asserted in the same cycle: the timer restarts with `count`=`load_value`.
  - `stop` alone: IDLE with `count` held.
- PWM: `load_value`=3, `compare_value`=2, `prescale`=0 → `pwm` is high while `count`∈{1,0}, i.e. 2 of every 4 cycles. `compare_value`=0 → `pwm` is never high.
- Reset mid-run: drive `reset`=0 with `count`=2 and `tp`=1, together with `start`=1. After that edge, all outputs are 0 and the state is IDLE.
